// File: rtl/sample_stream_arbiter_pkg.sv
// Shared types and widths for the sample stream arbiter.
// Pure declarations: no logic, no latency, no flow control.
package sample_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int BEAT_CNT_W = 4;

  // A single requester still needs a 1-bit index to keep port widths legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_stream_arbiter_if.sv
// Requester-side and stream-side handshake bundle around the arbiter.
// master = arbiter view, slave = sources plus the downstream sink.
interface sample_stream_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;

  modport master (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data
  );

  modport slave (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data
  );

endinterface

// File: rtl/sample_stream_arbiter_rr_priority_picker.sv
// Round-robin search: first set request at or above ptr, wrapping modulo NUM_REQ.
// Purely combinational, no state and no backpressure.
module rr_priority_picker
  import sample_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Walk offsets from far to near so the nearest hit overwrites earlier ones.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand     = (int'(ptr) + off) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sample_stream_arbiter.sv
// Burst-granular round-robin mux of NUM_REQ streams onto one valid/ready stream.
// One idle cycle per grant; out_ready passes straight to the owner's req_ready.
module sample_stream_arbiter
  import sample_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sample_stream_arbiter_if.master bus,
  output logic                  grant_active,
  output logic [ID_W-1:0]       grant_id,
  output logic [BEAT_CNT_W-1:0] beat_count
);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;
  logic [DATA_W-1:0] req_data_arr [NUM_REQ];
  logic              beat;
  logic              burst_end;
  logic [ID_W-1:0]   ptr_after_owner;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_active = (state == ARB_GRANT);
  assign beat         = grant_active && bus.req_valid[grant_id] && bus.out_ready;
  assign burst_end    = beat && (bus.req_last[grant_id] ||
                                 (beat_count == BEAT_CNT_W'(MAX_BURST - 1)));
  assign ptr_after_owner = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_found) state_nxt = ARB_GRANT;
      ARB_GRANT: if (burst_end)  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Only the owner sees out_ready; everything is forced quiet while idle.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.req_ready = '0;
    if (state == ARB_GRANT) begin
      bus.out_valid           = bus.req_valid[grant_id];
      bus.out_data            = req_data_arr[grant_id];
      bus.req_ready[grant_id] = bus.out_ready;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      beat_count <= '0;
      rr_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && pick_found) begin
        grant_id <= pick_idx;
      end
      if (burst_end) begin
        beat_count <= '0;
        rr_ptr     <= ptr_after_owner;
      end else if (beat) begin
        beat_count <= beat_count + 1'b1;
      end
    end
  end

endmodule
